// File: rtl/ccu_block_sched.sv
// Layer scheduler: steps through frames x blocks, pulsing enabled PE blocks and collecting their finish pulses.
// Define CCU_TIMEOUT_EN to build the sticky WAIT-state watchdog; otherwise timeout is tied low.
module ccu_block_sched #(
  parameter int NUM_PEB    = 16,
  parameter int PORT_WIDTH = 128,
  parameter int FRM_WIDTH  = 6,
  parameter int BLK_WIDTH  = 6,
  parameter int TO_LIMIT   = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IFCFG_val,
  input  logic [PORT_WIDTH-1:0] IFCFG_data,
  output logic                  CFGIF_rdy,
  output logic                  CFGGBPSUM_val,
  input  logic                  GBPSUMCFG_rdy,
  output logic [FRM_WIDTH-1:0]  CFGGBPSUM_num_frame,
  output logic [BLK_WIDTH-1:0]  CFGGBPSUM_num_block,
  output logic [NUM_PEB-1:0]    CCUPEB_next_block,
  input  logic [NUM_PEB-1:0]    PEBCCU_fnh_block,
  output logic [FRM_WIDTH-1:0]  CCUGB_frame,
  output logic [BLK_WIDTH-1:0]  CCUGB_block,
  output logic                  CCUPOOL_layer_fnh,
  input  logic                  POOLCCU_clear_up,
  output logic                  busy,
  output logic                  timeout
);
  localparam int CFG_USED = FRM_WIDTH + BLK_WIDTH + NUM_PEB;

  typedef enum logic [2:0] {IDLE, PSUM, ISSUE, WAIT, LAST} state_e;

  state_e               state_q, state_d;
  logic [FRM_WIDTH-1:0] frm_last_q, frm_last_d;
  logic [BLK_WIDTH-1:0] blk_last_q, blk_last_d;
  logic [NUM_PEB-1:0]   peb_en_q, peb_en_d;
  logic [FRM_WIDTH-1:0] frame_q, frame_d;
  logic [BLK_WIDTH-1:0] block_q, block_d;
  logic [NUM_PEB-1:0]   done_q, done_d;
  logic                 rst_hold_q, rst_hold_d;
  logic [NUM_PEB-1:0]   fnh_en;
  logic                 all_done;

  always_comb begin
    state_d    = state_q;
    frm_last_d = frm_last_q;
    blk_last_d = blk_last_q;
    peb_en_d   = peb_en_q;
    frame_d    = frame_q;
    block_d    = block_q;
    done_d     = done_q;
    rst_hold_d = 1'b0;
    fnh_en     = PEBCCU_fnh_block & peb_en_q;
    // A PEB finishing in the same cycle as the last outstanding one still counts.
    all_done   = ((done_q | fnh_en) & peb_en_q) == peb_en_q;
    unique case (state_q)
      IDLE: begin
        if (IFCFG_val) begin
          frm_last_d = IFCFG_data[FRM_WIDTH-1:0];
          blk_last_d = IFCFG_data[FRM_WIDTH +: BLK_WIDTH];
          peb_en_d   = IFCFG_data[FRM_WIDTH+BLK_WIDTH +: NUM_PEB];
          frame_d    = '0;
          block_d    = '0;
          done_d     = '0;
          state_d    = PSUM;
        end
      end
      PSUM: begin
        if (GBPSUMCFG_rdy) state_d = ISSUE;
      end
      ISSUE: begin
        done_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        done_d = done_q | fnh_en;
        if (all_done) begin
          if (block_q < blk_last_q) begin
            block_d = block_q + 1'b1;
            state_d = ISSUE;
          end else if (frame_q < frm_last_q) begin
            block_d = '0;
            frame_d = frame_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        if (POOLCCU_clear_up) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frm_last_q <= '0;
      blk_last_q <= '0;
      peb_en_q   <= '0;
      frame_q    <= '0;
      block_q    <= '0;
      done_q     <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      frm_last_q <= frm_last_d;
      blk_last_q <= blk_last_d;
      peb_en_q   <= peb_en_d;
      frame_q    <= frame_d;
      block_q    <= block_d;
      done_q     <= done_d;
      rst_hold_q <= rst_hold_d;
    end
  end

`ifdef CCU_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Counter tracks elapsed WAIT cycles; flag rises on the edge the count reaches TO_LIMIT.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE && IFCFG_val) begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (state_q == ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (wd_cnt_q != 16'hFFFF) wd_cnt_d = wd_cnt_q + 16'd1;
      if (({1'b0, wd_cnt_q} + 17'd1) >= 17'(TO_LIMIT)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic [15:0] unused_to_limit;
  assign unused_to_limit = 16'(TO_LIMIT);
  assign timeout         = 1'b0;
`endif

  generate
    if (PORT_WIDTH > CFG_USED) begin : g_spare_bits
      logic unused_cfg_bits;
      assign unused_cfg_bits = ^IFCFG_data[PORT_WIDTH-1:CFG_USED];
    end
  endgenerate

  // Ready is held low for the cycle right after a reset edge so every output reads zero then.
  assign CFGIF_rdy           = (state_q == IDLE) && !rst_hold_q;
  assign CFGGBPSUM_val       = (state_q == PSUM);
  assign CFGGBPSUM_num_frame = frm_last_q;
  assign CFGGBPSUM_num_block = blk_last_q;
  assign CCUPEB_next_block   = (state_q == ISSUE) ? peb_en_q : '0;
  assign CCUGB_frame         = frame_q;
  assign CCUGB_block         = block_q;
  assign CCUPOOL_layer_fnh   = (state_q == LAST);
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_ccu_block_sched.sv
`timescale 1ns/1ps
// Bench for ccu_block_sched: layers are checked against a frame/block schedule model built from PEB finish delays.
module tb_ccu_block_sched;
  localparam int NUM_PEB    = 16;
  localparam int PORT_WIDTH = 128;
  localparam int FRM_WIDTH  = 6;
  localparam int BLK_WIDTH  = 6;
  localparam int TO_LIMIT   = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  IFCFG_val;
  logic [PORT_WIDTH-1:0] IFCFG_data;
  logic                  CFGIF_rdy;
  logic                  CFGGBPSUM_val;
  logic                  GBPSUMCFG_rdy;
  logic [FRM_WIDTH-1:0]  CFGGBPSUM_num_frame;
  logic [BLK_WIDTH-1:0]  CFGGBPSUM_num_block;
  logic [NUM_PEB-1:0]    CCUPEB_next_block;
  logic [NUM_PEB-1:0]    PEBCCU_fnh_block;
  logic [FRM_WIDTH-1:0]  CCUGB_frame;
  logic [BLK_WIDTH-1:0]  CCUGB_block;
  logic                  CCUPOOL_layer_fnh;
  logic                  POOLCCU_clear_up;
  logic                  busy;
  logic                  timeout;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ccu_block_sched #(
    .NUM_PEB(NUM_PEB), .PORT_WIDTH(PORT_WIDTH), .FRM_WIDTH(FRM_WIDTH),
    .BLK_WIDTH(BLK_WIDTH), .TO_LIMIT(TO_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .IFCFG_val(IFCFG_val), .IFCFG_data(IFCFG_data), .CFGIF_rdy(CFGIF_rdy),
    .CFGGBPSUM_val(CFGGBPSUM_val), .GBPSUMCFG_rdy(GBPSUMCFG_rdy),
    .CFGGBPSUM_num_frame(CFGGBPSUM_num_frame), .CFGGBPSUM_num_block(CFGGBPSUM_num_block),
    .CCUPEB_next_block(CCUPEB_next_block), .PEBCCU_fnh_block(PEBCCU_fnh_block),
    .CCUGB_frame(CCUGB_frame), .CCUGB_block(CCUGB_block),
    .CCUPOOL_layer_fnh(CCUPOOL_layer_fnh), .POOLCCU_clear_up(POOLCCU_clear_up),
    .busy(busy), .timeout(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({CFGIF_rdy, CFGGBPSUM_val, CFGGBPSUM_num_frame, CFGGBPSUM_num_block,
                CCUPEB_next_block, CCUGB_frame, CCUGB_block, CCUPOOL_layer_fnh, busy, timeout});
  endfunction

  function automatic logic [PORT_WIDTH-1:0] make_word(input int f1, input int b1,
                                                     input logic [NUM_PEB-1:0] en);
    logic [PORT_WIDTH-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[FRM_WIDTH-1:0] = FRM_WIDTH'(f1);
    w[FRM_WIDTH +: BLK_WIDTH] = BLK_WIDTH'(b1);
    w[FRM_WIDTH+BLK_WIDTH +: NUM_PEB] = en;
    return w;
  endfunction

  task automatic drive_junk();
    IFCFG_val  = 1'($urandom_range(0, 1));
    IFCFG_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode 0: random delays, spurious/duplicate/noise fnh; mode 1: every PEB finishes 3 cycles
  // after its pulse; mode 2: PEB0 at 2 (duplicate at 5), PEB3 at 9.
  task automatic run_layer(input int f1, input int b1, input logic [NUM_PEB-1:0] en,
                           input int mode, input int stall, output int lat);
    logic [NUM_PEB-1:0] fnh_v;
    int dly [NUM_PEB];
    int acc_cyc, pulse_cyc, next_cyc, n_pulses, total, max_d, k, psum_cycles, exp_f, exp_b;
    lat = -1;
    n_run++;
    if (CFGIF_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_rdy: got %b expected 1", CFGIF_rdy);
    end
    IFCFG_val        = 1'b1;
    IFCFG_data       = make_word(f1, b1, en);
    GBPSUMCFG_rdy    = 1'b0;
    POOLCCU_clear_up = 1'b0;
    PEBCCU_fnh_block = NUM_PEB'($urandom);
    step();
    acc_cyc     = cyc;
    psum_cycles = (stall > 0) ? stall : 1;
    for (int s = 0; s < psum_cycles; s++) begin
      n_run++;
      if ({CFGGBPSUM_val, CFGIF_rdy, busy, CCUPEB_next_block} !== {1'b1, 1'b0, 1'b1, 16'h0}) begin
        n_fail++;
        $display("FAIL psum_hold: cycle %0d got val/rdy/busy/next=%b/%b/%b/%h expected 1/0/1/0000",
                 s, CFGGBPSUM_val, CFGIF_rdy, busy, CCUPEB_next_block);
      end
      n_run++;
      if ({CFGGBPSUM_num_frame, CFGGBPSUM_num_block} !== {FRM_WIDTH'(f1), BLK_WIDTH'(b1)}) begin
        n_fail++;
        $display("FAIL psum_nums: got %0d/%0d expected %0d/%0d",
                 CFGGBPSUM_num_frame, CFGGBPSUM_num_block, f1, b1);
      end
      GBPSUMCFG_rdy    = (s == psum_cycles - 1);
      PEBCCU_fnh_block = NUM_PEB'($urandom);
      drive_junk();
      step();
    end
    GBPSUMCFG_rdy = 1'($urandom_range(0, 1));
    next_cyc  = cyc;
    pulse_cyc = cyc;
    n_pulses  = 0;
    total     = (f1 + 1) * (b1 + 1);
    forever begin
      if (cyc - acc_cyc > 2000) begin
        n_run++;
        n_fail++;
        $display("FAIL layer_budget: got no layer end after %0d cycles expected %0d pulses", cyc - acc_cyc, total);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        return;
      end
      if (cyc == next_cyc && n_pulses < total) begin
        exp_f = n_pulses / (b1 + 1);
        exp_b = n_pulses % (b1 + 1);
        n_run++;
        if (CCUPEB_next_block !== en || CCUPOOL_layer_fnh !== 1'b0) begin
          n_fail++;
          $display("FAIL issue_pulse: pulse %0d got %h/%b expected %h/0", n_pulses, CCUPEB_next_block, CCUPOOL_layer_fnh, en);
        end
        n_run++;
        if ({CCUGB_frame, CCUGB_block} !== {FRM_WIDTH'(exp_f), BLK_WIDTH'(exp_b)}) begin
          n_fail++;
          $display("FAIL frame_block: pulse %0d got (%0d,%0d) expected (%0d,%0d)",
                   n_pulses, CCUGB_frame, CCUGB_block, exp_f, exp_b);
        end
        max_d = 1;
        for (int i = 0; i < NUM_PEB; i++) begin
          if (mode == 1) dly[i] = 3;
          else if (mode == 2) dly[i] = (i == 0) ? 2 : ((i == 3) ? 9 : 1);
          else dly[i] = $urandom_range(1, 6);
          if (en[i] && dly[i] > max_d) max_d = dly[i];
        end
        pulse_cyc = cyc;
        next_cyc  = cyc + max_d + 1;
        n_pulses++;
      end else if (cyc == next_cyc) begin
        n_run++;
        if ({CCUPOOL_layer_fnh, CCUPEB_next_block, CCUGB_frame, CCUGB_block} !==
            {1'b1, 16'h0, FRM_WIDTH'(f1), BLK_WIDTH'(b1)}) begin
          n_fail++;
          $display("FAIL layer_end: got fnh=%b next=%h (%0d,%0d) expected 1 0000 (%0d,%0d)",
                   CCUPOOL_layer_fnh, CCUPEB_next_block, CCUGB_frame, CCUGB_block, f1, b1);
        end
        lat = cyc - acc_cyc;
        break;
      end else begin
        n_run++;
        if ({CCUPEB_next_block, CCUPOOL_layer_fnh, busy, CFGIF_rdy} !== {16'h0, 1'b0, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL wait_quiet: cycle %0d got next=%h fnh=%b busy=%b rdy=%b expected 0000 0 1 0",
                   cyc - acc_cyc, CCUPEB_next_block, CCUPOOL_layer_fnh, busy, CFGIF_rdy);
        end
      end
      k = cyc - pulse_cyc;
      fnh_v = (mode == 0) ? (NUM_PEB'($urandom) & ~en) : '0;
      for (int i = 0; i < NUM_PEB; i++) begin
        if (en[i]) begin
          if (k == dly[i]) fnh_v[i] = 1'b1;
          else if (mode == 0 && k == 0) fnh_v[i] = 1'($urandom_range(0, 1));
          else if (mode == 0 && k > dly[i]) fnh_v[i] = ($urandom_range(0, 3) == 0);
          else if (mode == 2 && i == 0 && k == 5) fnh_v[i] = 1'b1;
        end
      end
      PEBCCU_fnh_block = fnh_v;
      drive_junk();
      step();
    end
    for (int h = 0; h < 3; h++) begin
      PEBCCU_fnh_block = NUM_PEB'($urandom);
      drive_junk();
      step();
      n_run++;
      if ({CCUPOOL_layer_fnh, CCUPEB_next_block, CFGIF_rdy} !== {1'b1, 16'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL last_hold: got fnh=%b next=%h rdy=%b expected 1 0000 0",
                 CCUPOOL_layer_fnh, CCUPEB_next_block, CFGIF_rdy);
      end
    end
    IFCFG_val        = 1'b0;
    POOLCCU_clear_up = 1'b1;
    PEBCCU_fnh_block = '0;
    step();
    POOLCCU_clear_up = 1'b0;
    n_run++;
    if ({CCUPOOL_layer_fnh, busy, CFGIF_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL clear_up: got fnh/busy/rdy=%b%b%b expected 001", CCUPOOL_layer_fnh, busy, CFGIF_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_run++;
    if (outs_vec() !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h expected 0", outs_vec());
    end
    rst = 1'b0;
    step();
    n_run++;
    if ({CFGIF_rdy, busy, CFGGBPSUM_val, CCUPEB_next_block, timeout} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b busy=%b val=%b next=%h to=%b expected 1 0 0 0000 0",
               CFGIF_rdy, busy, CFGGBPSUM_val, CCUPEB_next_block, timeout);
    end
  endtask

  task automatic test_basic_layer();
    int lat;
    run_layer(1, 2, 16'h000F, 1, 0, lat);
  endtask

  task automatic test_partial_finish();
    int lat;
    run_layer(0, 1, 16'h0009, 2, 0, lat);
  endtask

  task automatic test_psum_stall();
    int lat;
    run_layer(0, 1, NUM_PEB'($urandom), 0, 6, lat);
  endtask

  task automatic test_peb_en_zero();
    int lat;
    run_layer(0, 0, 16'h0000, 1, 0, lat);
    n_run++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL peb_en_zero_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_random_layers();
    int lat;
    logic [NUM_PEB-1:0] en;
    for (int r = 0; r < 8; r++) begin
      en = ($urandom_range(0, 3) == 0) ? '0 : NUM_PEB'($urandom);
      run_layer($urandom_range(0, 3), $urandom_range(0, 3), en, 0, $urandom_range(0, 3), lat);
    end
  endtask

  task automatic test_reset_mid();
    IFCFG_val     = 1'b1;
    IFCFG_data    = make_word(1, 1, 16'h000F);
    GBPSUMCFG_rdy = 1'b1;
    step();
    IFCFG_val = 1'b0;
    step();
    step();
    PEBCCU_fnh_block = 16'h0003;
    step();
    rst = 1'b1;
    step();
    n_run++;
    if (outs_vec() !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got %h expected 0", outs_vec());
    end
    rst = 1'b0;
    step();
    n_run++;
    if ({CFGIF_rdy, busy, CCUGB_frame, CCUGB_block} !== {1'b1, 1'b0, 12'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_release: got rdy=%b busy=%b (%0d,%0d) expected 1 0 (0,0)",
               CFGIF_rdy, busy, CCUGB_frame, CCUGB_block);
    end
    for (int i = 0; i < 8; i++) begin
      PEBCCU_fnh_block = NUM_PEB'($urandom);
      step();
      n_run++;
      if ({CCUPEB_next_block, busy, CCUPOOL_layer_fnh} !== {16'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL mid_reset_quiet: got next=%h busy=%b fnh=%b expected 0000 0 0",
                 CCUPEB_next_block, busy, CCUPOOL_layer_fnh);
      end
    end
    PEBCCU_fnh_block = '0;
  endtask

  task automatic test_timeout();
    logic exp_to;
    exp_to           = 1'b0;
    IFCFG_val        = 1'b1;
    IFCFG_data       = make_word(0, 0, 16'h0001);
    GBPSUMCFG_rdy    = 1'b1;
    PEBCCU_fnh_block = '0;
    step();
    IFCFG_val = 1'b0;
    step();
    step();
    for (int i = 1; i <= 14; i++) begin
      step();
`ifdef CCU_TIMEOUT_EN
      exp_to = (i >= TO_LIMIT);
`else
      exp_to = 1'b0;
`endif
      n_run++;
      if ({timeout, busy, CCUPOOL_layer_fnh, CCUPEB_next_block} !== {exp_to, 1'b1, 1'b0, 16'h0}) begin
        n_fail++;
        $display("FAIL watchdog: wait cycle %0d got to=%b busy=%b fnh=%b next=%h expected %b 1 0 0000",
                 i, timeout, busy, CCUPOOL_layer_fnh, CCUPEB_next_block, exp_to);
      end
    end
    PEBCCU_fnh_block = 16'h0001;
    step();
    PEBCCU_fnh_block = '0;
    POOLCCU_clear_up = 1'b1;
    n_run++;
    if ({CCUPOOL_layer_fnh, timeout} !== {1'b1, exp_to}) begin
      n_fail++;
      $display("FAIL watchdog_sticky: got fnh=%b to=%b expected 1 %b", CCUPOOL_layer_fnh, timeout, exp_to);
    end
    step();
    POOLCCU_clear_up = 1'b0;
    IFCFG_val        = 1'b1;
    IFCFG_data       = make_word(0, 0, 16'h0000);
    step();
    IFCFG_val = 1'b0;
    n_run++;
    if ({CFGGBPSUM_val, timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL watchdog_clear: got val=%b to=%b expected 1 0", CFGGBPSUM_val, timeout);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst              = 1'b1;
    IFCFG_val        = 1'b0;
    IFCFG_data       = '0;
    GBPSUMCFG_rdy    = 1'b0;
    PEBCCU_fnh_block = '0;
    POOLCCU_clear_up = 1'b0;
    test_reset();
    test_basic_layer();
    test_partial_finish();
    test_psum_stall();
    test_peb_en_zero();
    test_random_layers();
    test_reset_mid();
    test_random_layers();
    test_timeout();
    test_basic_layer();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ccu_block_sched.md
CCU_BLOCK_SCHED -- requirements
Module: ccu_block_sched

Interface
Parameters, one per line (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_PEB, default 16: number of PE blocks scheduled.
REQ-002 The block SHALL have parameter PORT_WIDTH, default 128: config word width.
REQ-003 The block SHALL have parameter FRM_WIDTH, default 6: frame counter width.
REQ-004 The block SHALL have parameter BLK_WIDTH, default 6: block counter width.
REQ-005 The block SHALL have parameter TO_LIMIT, default 65535: watchdog cycle limit, 16-bit.

Ports, one per line (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port IFCFG_val, input, 1: config word valid.
REQ-009 The block SHALL have port IFCFG_data, input, PORT_WIDTH: config word.
REQ-010 The block SHALL have port CFGIF_rdy, output, 1: ready to accept config.
REQ-011 The block SHALL have port CFGGBPSUM_val, output, 1: psum buffer config valid.
REQ-012 The block SHALL have port GBPSUMCFG_rdy, input, 1: psum buffer ready.
REQ-013 The block SHALL have ports CFGGBPSUM_num_frame, output, FRM_WIDTH, and CFGGBPSUM_num_block, output, BLK_WIDTH: registered layer counts.
REQ-014 The block SHALL have port CCUPEB_next_block, output, NUM_PEB: per-PEB start-block pulse.
REQ-015 The block SHALL have port PEBCCU_fnh_block, input, NUM_PEB: per-PEB block-finished pulse.
REQ-016 The block SHALL have ports CCUGB_frame, output, FRM_WIDTH, and CCUGB_block, output, BLK_WIDTH: current frame and block index.
REQ-017 The block SHALL have port CCUPOOL_layer_fnh, output, 1: layer done, level.
REQ-018 The block SHALL have port POOLCCU_clear_up, input, 1: pool acknowledges layer end.
REQ-019 The block SHALL have port busy, output, 1: high in any state except IDLE.
REQ-020 The block SHALL have port timeout, output, 1: sticky watchdog flag.

Function
REQ-021 The config word SHALL be decoded as: bits [FRM_WIDTH-1:0] = frames-1; next BLK_WIDTH bits = blocks-1; next NUM_PEB bits = peb_en mask. PORT_WIDTH SHALL be >= FRM_WIDTH+BLK_WIDTH+NUM_PEB.
REQ-022 The FSM SHALL have states IDLE, PSUM, ISSUE, WAIT, LAST.
REQ-023 IDLE: CFGIF_rdy=1; when IFCFG_val=1 the block SHALL register the fields, clear the frame and block counters, and go to PSUM on the next cycle.
REQ-024 PSUM: CFGGBPSUM_val SHALL be 1; CFGGBPSUM_num_* SHALL carry the registered fields; on GBPSUMCFG_rdy=1 the FSM SHALL go to ISSUE.
REQ-025 ISSUE: lasts exactly one cycle; CCUPEB_next_block SHALL equal peb_en; the per-PEB done register SHALL clear; the FSM then goes to WAIT.
REQ-026 WAIT: done |= PEBCCU_fnh_block & peb_en. PEBCCU_fnh_block SHALL be sampled only in WAIT and ignored in every other state.
REQ-027 WAIT exit: when (done | fnh) & peb_en == peb_en, the block counter SHALL advance in that cycle.
  - If block < blocks-1: go to ISSUE.
  - Otherwise, block wraps to 0 and frame increments, then go to ISSUE.
  - If this was the last frame and last block: go to LAST; counters hold their final values.
REQ-028 If peb_en=0, WAIT SHALL exit in its first cycle.
REQ-029 LAST: CCUPOOL_layer_fnh SHALL be 1; on POOLCCU_clear_up=1 the FSM SHALL go to IDLE and CCUPOOL_layer_fnh SHALL drop in the same transition.
REQ-030 CFGIF_rdy SHALL be 0 outside IDLE; config words presented then SHALL be ignored.
REQ-031 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-032 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and all counters, config registers, done, watchdog and timeout SHALL go to 0.
REQ-033 Reset value of every output SHALL be 0, except CFGIF_rdy, which SHALL be 1 in the first cycle after rst deasserts.
REQ-034 A reset mid-layer SHALL abandon the layer and emit no further pulses.

Configuration
REQ-035 With macro CCU_TIMEOUT_EN defined: a 16-bit counter SHALL count WAIT cycles and clear on ISSUE. At count==TO_LIMIT, timeout SHALL set and hold until reset or the next config is accepted. The FSM SHALL be unaffected.
REQ-036 Without CCU_TIMEOUT_EN: the timeout port SHALL still exist and SHALL be tied to 0, and no counter logic SHALL be built.

Verification
REQ-037 The bench SHALL cover: config frames-1=1, blocks-1=2, peb_en=16'h000F, all PEBs finish 3 cycles after each pulse -> 6 next_block pulses of 16'h000F, (frame,block) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), then layer_fnh=1.
REQ-038 The bench SHALL cover: PEB0 finishes in cycle 2 and PEB3 in cycle 9 -> ISSUE only after PEB3; a duplicate PEB0 fnh is harmless.
REQ-039 The bench SHALL cover: GBPSUMCFG_rdy held low for 5 cycles -> CFGGBPSUM_val stays 1 and no next_block pulse is issued.
REQ-040 The bench SHALL cover: peb_en=0 with frames-1=0, blocks-1=0 -> LAST reached 3 cycles after config acceptance.
REQ-041 The bench SHALL cover: rst during WAIT -> outputs 0 next cycle, then CFGIF_rdy=1.
REQ-042 The bench SHALL cover: with CCU_TIMEOUT_EN and TO_LIMIT=10, no fnh -> timeout=1 after 10 WAIT cycles, FSM remains in WAIT.
